cordic_seg7_display: RTL and testbench
======================================

Name: cordic_seg7_display

Overview:
- Downstream consumer of the pipelined CORDIC core's 32-bit angle/result word.
- Converts a signed Q1.30 value to sign plus 7 decimal digits, formatted `[s][d].[dddddd]`.
- Time-multiplexes the digits onto the board's 8-digit common-anode seven-segment display.
- Conversion is an iterative multiply plus double-dabble FSM; the display scan runs continuously and independently of it.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Minimum 2; benches use 4.
- SCALE, 1000000: decimal scale applied to the fractional magnitude (6 fractional digits).
- BCD_BITS, 21: width of the scaled magnitude; 2,000,000 < 2^21.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  32  signed Q1.30 value (0x40000000 = +1.0), sampled when din_valid is high.
- din_valid  in  1  one-cycle qualifier for din.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse when the display register updates.
- an  out  8  digit enables, active-low; an[0] is the rightmost digit.
- c  out  8  cathodes, active-low: c[7]=dp, c[6:0]=g,f,e,d,c,b,a.

Behaviour:
- Reset (synchronous, active-high):
  - an=8'hFF, c=8'hFF, busy=0, done=0.
  - Refresh counter=0, digit index=0, pending flag cleared.
  - Display register = value 0, shown as " 0.000000".
- Scan:
  - Counter counts 0..REFRESH_DIV-1. On wrap, the digit index increments 0..7 and wraps 7→0.
  - an = ~(1<<idx); c = glyph of the indexed digit. Both are registered.
  - First cycle after reset release: an=8'hFE.
- FSM states IDLE, MUL, CONV, LOAD:
  - IDLE, din_valid seen: capture sign = din[31] and mag = |din| (33-bit, so -2^31 is safe), then go to MUL.
  - MUL (1 cycle): scaled = (mag*SCALE + 2^29) >> 30. This is round-half-up, 0..2,000,000.
  - CONV (21 cycles): double-dabble shift into 7 BCD nibbles.
  - LOAD (1 cycle): write the display register, pulse done, then return to IDLE (or MUL, see pending).
- busy is high in MUL, CONV and LOAD.
- Latency: din_valid sampled at edge N → done high and new digits in the display register from edge N+23.
- Formatting:
  - digit7: '-' if sign=1 and scaled≠0, else blank. No "-0".
  - digit6: integer digit with dp lit.
  - digits5..0: fractional digits, no leading-zero blanking.
- din_valid while busy:
  - Goes into a single-deep pending register; the latest write wins.
  - LOAD with pending set goes straight to MUL with the pending value and clears pending. done still pulses for the completed conversion.
- din_valid coincident with LOAD: captured into pending.
- Reset mid-conversion: the conversion is abandoned, the pending value is discarded, and the display returns to " 0.000000".

Optional Feature:
- Macro: DISP_HEX_BYPASS_EN.
- Defined:
  - Adds input port hex_mode (1 bit).
  - hex_mode=1: din_valid loads din directly into the display as 8 hex digits. No FSM activity, latency 1 edge, done pulses, dp off.
  - hex_mode=0: decimal behaviour as above.
  - A hex load while busy is written to pending and handled like any other pending value.
- Undefined: no port, no hex path. Glyphs A–F are still present in the decoder.

Decomposition:
- Package cordic_disp_pkg holds:
  - state enum {IDLE, MUL, CONV, LOAD}.
  - Constants NDIG=8, SCALE, BCD_BITS, ROUND_K=2^29.
  - 5-bit glyph codes: 0–15 hex, GLYPH_MINUS=16, GLYPH_BLANK=17.
  - Segment patterns.
- One sub-module: seg7_glyph_decode. It is combinational and maps a 5-bit code plus dp to c[7:0] (e.g. '0'→0x40, '-'→0xBF, blank→0xFF).

Test Plan:
- Reset and scan, REFRESH_DIV=4: reset held 2 cycles → an=FF, c=FF.
  - After release: an=FE, c=C0 (digit0 '0').
  - After 4 cycles: an=FD.
  - Digit6 shows '0.' (c=0x40); digit7 shows blank (c=FF).
- din=0x40000000 → done exactly 23 edges later; display " 1.000000".
  - Digit6 c=0x79, digit7 c=FF, digits5..0 c=C0.
- din=0xC0000000 → "-1.000000": digit7 c=BF, digit6 c=0x79.
  - Then din=0xFFFFFFFF → " 0.000000": digit7 blank, no "-0".
- din=0x80000000 → "-2.000000": digit6 c=0x24.
  - Then din=0x20000000 → " 0.500000": digit5 c=0x92.
- Back-to-back inputs: 0x40000000, then 0x20000000 at +3 cycles, then 0x10000000 at +5 cycles.
  - Exactly 2 done pulses.
  - Final display " 0.250000" (digit5 c=0xA4, digit4 c=0x92).
- Assert reset mid-CONV → busy=0 next cycle, display " 0.000000", no done pulse.

Source files
------------

// File: rtl/cordic_disp_pkg.sv
// Shared types and constants for the CORDIC seven-segment display:
// FSM states, glyph codes, segment patterns and the double-dabble step.
package cordic_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    CONV,
    LOAD
  } state_e;

  localparam int NDIG     = 8;
  localparam int SCALE    = 1000000;
  localparam int BCD_BITS = 21;
  localparam int ROUND_K  = 1 << 29;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_MINUS = 5'd16;
  localparam glyph_t GLYPH_BLANK = 5'd17;

  // Active-low g,f,e,d,c,b,a
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Add 3 to every BCD nibble >= 5 ahead of the shift
  function automatic logic [27:0] dd_adj(
    input logic [27:0] b
  );
    logic [27:0] r;
    r = b;
    for (int i = 0; i < 7; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: 5-bit glyph code plus decimal point to
// active-low cathodes. Ports: code_i, dp_i -> c_o {dp,g,f,e,d,c,b,a}.
module seg7_glyph_decode
  import cordic_disp_pkg::*;
(
  input  glyph_t     code_i,
  input  logic       dp_i,
  output logic [7:0] c_o
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_BLANK;
    unique case (1'b1)
      !code_i[4]:             seg = SEG_HEX[code_i[3:0]];
      code_i == GLYPH_MINUS:  seg = SEG_MINUS;
      default:                seg = SEG_BLANK;
    endcase
  end

  assign c_o = {~dp_i, seg};

endmodule

// File: rtl/cordic_seg7_display.sv
// Q1.30 to "[s][d].[dddddd]" converter with multiplexed 8-digit display.
// Ports: clk, reset (sync, high), din/din_valid in; busy, done, an, c out.
// Optional DISP_HEX_BYPASS_EN adds hex_mode: raw 8-digit hex display.
module cordic_seg7_display
  import cordic_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        din_valid,
`ifdef DISP_HEX_BYPASS_EN
  input  logic        hex_mode,
`endif
  output logic        busy,
  output logic        done,
  output logic [7:0]  an,
  output logic [7:0]  c
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e state_q, state_d;

  logic                sign_q;
  logic [32:0]         mag_q;
  logic [BCD_BITS-1:0] bin_q;
  logic [27:0]         bcd_q;
  logic [4:0]          bit_q;
  logic                pend_q;
  logic                pend_hex_q;
  logic [31:0]         pend_din_q;
  glyph_t [NDIG-1:0]   glyph_q;
  logic [NDIG-1:0]     dp_q;
  logic                done_q;

  logic [CW-1:0]       rcnt_q;
  logic [2:0]          idx_q;
  logic [7:0]          an_q;
  logic [7:0]          c_q;
  logic [7:0]          seg_c;

  logic                hex_w;
  logic                src_v;
  logic                src_hex;
  logic [31:0]         src_din;
  logic [32:0]         src_ext;
  logic [32:0]         src_mag;
  logic                take;
  logic                go_dec;
  logic                hex_ld;
  logic [50:0]         prod;
  logic [BCD_BITS-1:0] scaled;
  logic [BCD_BITS+27:0] dd_cat;

`ifdef DISP_HEX_BYPASS_EN
  assign hex_w = hex_mode;
`else
  assign hex_w = 1'b0;
`endif

  // A fresh din_valid always wins over a held pending value
  assign src_v   = din_valid | pend_q;
  assign src_din = din_valid ? din : pend_din_q;
  assign src_hex = din_valid ? hex_w : pend_hex_q;
  assign src_ext = {src_din[31], src_din};
  assign src_mag = src_din[31] ? 33'd0 - src_ext
                               : src_ext;

  assign take   = (state_q == IDLE) ||
                  (state_q == LOAD);
  assign go_dec = take && src_v && !src_hex;
  // Hex loads wait for IDLE so they never collide with a LOAD write
  assign hex_ld = (state_q == IDLE) && src_v && src_hex;

  assign prod   = 51'(mag_q) * 51'(SCALE) + 51'(ROUND_K);
  assign scaled = BCD_BITS'(prod >> 30);
  assign dd_cat = {dd_adj(bcd_q), bin_q};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go_dec) state_d = MUL;
      MUL:  state_d = CONV;
      CONV: if (bit_q == 5'(BCD_BITS - 1))
              state_d = LOAD;
      LOAD: state_d = go_dec ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_hex_q <= 1'b0;
      pend_din_q <= '0;
    end else if (go_dec || hex_ld) begin
      pend_q     <= 1'b0;
    end else if (din_valid && state_q != IDLE) begin
      pend_q     <= 1'b1;
      pend_hex_q <= hex_w;
      pend_din_q <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      bit_q   <= '0;
      done_q  <= 1'b0;
      glyph_q <= '0;
      glyph_q[NDIG-1] <= GLYPH_BLANK;
      dp_q    <= 8'h40;
    end else begin
      done_q <= 1'b0;
      if (go_dec) begin
        sign_q <= src_din[31];
        mag_q  <= src_mag;
      end
      unique case (state_q)
        MUL: begin
          bin_q <= scaled;
          bcd_q <= '0;
          bit_q <= '0;
        end
        CONV: begin
          {bcd_q, bin_q} <= dd_cat << 1;
          bit_q <= bit_q + 5'd1;
        end
        LOAD: begin
          for (int i = 0; i < 7; i++)
            glyph_q[i] <= {1'b0, bcd_q[4*i +: 4]};
          // No "-0" when the magnitude rounds to zero
          glyph_q[7] <= (sign_q && bcd_q != '0)
                        ? GLYPH_MINUS : GLYPH_BLANK;
          dp_q   <= 8'h40;
          done_q <= 1'b1;
        end
        default: ;
      endcase
      if (hex_ld) begin
        for (int i = 0; i < NDIG; i++)
          glyph_q[i] <= {1'b0, src_din[4*i +: 4]};
        dp_q   <= '0;
        done_q <= 1'b1;
      end
    end
  end

  seg7_glyph_decode u_dec (
    .code_i (glyph_q[idx_q]),
    .dp_i   (dp_q[idx_q]),
    .c_o    (seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      an_q   <= 8'hFF;
      c_q    <= 8'hFF;
    end else begin
      if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
        rcnt_q <= '0;
        idx_q  <= idx_q + 3'd1;
      end else begin
        rcnt_q <= rcnt_q + CW'(1);
      end
      an_q <= ~(8'd1 << idx_q);
      c_q  <= seg_c;
    end
  end

  assign done = done_q;
  assign an   = an_q;
  assign c    = c_q;

endmodule

// File: tb/tb_cordic_seg7_display.sv
// Scoreboard bench for cordic_seg7_display: expected done cycles and
// display contents are queued at stimulus time and checked by monitors.
module tb_cordic_seg7_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        busy, done;
  logic [7:0]  an, c;

  always #5 clk = ~clk;

  cordic_seg7_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
`ifdef DISP_HEX_BYPASS_EN
    .hex_mode  (1'b0),
`endif
    .busy      (busy),
    .done      (done),
    .an        (an),
    .c         (c)
  );

  typedef logic [7:0][7:0] disp_t;
  typedef struct {
    int    cyc;
    bit    chk;
    disp_t d;
  } exp_t;
  typedef struct {
    logic [31:0] v;
    bit          neg;
    int          ip;
    int          frac;
  } vec_t;

  exp_t  exp_q[$];
  disp_t scan_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    n_done = 0;
  bit    scan_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  function automatic logic [7:0] seg(input int d,
                                     input bit dp);
    logic [7:0] t;
    case (d)
      0: t = 8'hC0;
      1: t = 8'hF9;
      2: t = 8'hA4;
      3: t = 8'hB0;
      4: t = 8'h99;
      5: t = 8'h92;
      6: t = 8'h82;
      7: t = 8'hF8;
      8: t = 8'h80;
      9: t = 8'h90;
      default: t = 8'hFF;
    endcase
    if (dp) t[7] = 1'b0;
    return t;
  endfunction

  function automatic disp_t mk(input bit neg,
                               input int ip,
                               input int frac);
    disp_t r;
    int f;
    f = frac;
    for (int k = 0; k < 6; k++) begin
      r[k] = seg(f % 10, 1'b0);
      f = f / 10;
    end
    r[6] = seg(ip, 1'b1);
    r[7] = neg ? 8'hBF : 8'hFF;
    return r;
  endfunction

  // Done monitor: every pulse must match a queued expectation
  always @(negedge clk) begin : done_mon
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        if (e.chk) scan_q.push_back(e.d);
      end
    end
  end

  // Scan monitor: walks all 8 digit positions and checks cathodes
  initial begin : scan_mon
    disp_t d;
    int t;
    logic [7:0] want;
    forever begin
      wait (scan_q.size() != 0);
      d = scan_q.pop_front();
      scan_busy = 1;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
        want = ~(8'h01 << k);
        t = 0;
        @(negedge clk);
        while (an !== want && t < 64) begin
          @(negedge clk);
          t++;
        end
        if (t >= 64)
          chk($sformatf("scan_timeout_d%0d", k), an, want);
        else
          chk($sformatf("digit%0d_c", k), c, d[k]);
      end
      scan_busy = 0;
    end
  end

  task automatic push(input int ecyc, input bit ck,
                      input disp_t d);
    exp_t e;
    e.cyc = ecyc;
    e.chk = ck;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] v);
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(posedge clk);
    while ((exp_q.size() != 0 || scan_q.size() != 0 ||
            scan_busy) && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_idle"}, 32'(t < 400), 32'd1);
    @(negedge clk);
  endtask

  vec_t vecs[8] = '{
    '{32'h40000000, 1'b0, 1, 0},
    '{32'hC0000000, 1'b1, 1, 0},
    '{32'hFFFFFFFF, 1'b0, 0, 0},
    '{32'h80000000, 1'b1, 2, 0},
    '{32'h20000000, 1'b0, 0, 500000},
    '{32'h06666666, 1'b0, 0, 100000},
    '{32'h3FFFFFFF, 1'b0, 1, 0},
    '{32'h7FFFFFFF, 1'b0, 2, 0}
  };

  initial begin : stim
    int c0;
    int nd0;
    disp_t none;
    none = '1;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_an", an, 8'hFF);
    chk("reset_c", c, 8'hFF);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_an", an, 8'hFE);
    chk("first_c", c, 8'hC0);
    repeat (4) @(negedge clk);
    chk("scan_an", an, 8'hFD);
    scan_q.push_back(mk(1'b0, 0, 0));
    wait_idle("reset_disp");

    foreach (vecs[i]) begin
      c0 = cyc;
      push(c0 + 24, 1'b1,
           mk(vecs[i].neg, vecs[i].ip, vecs[i].frac));
      send(vecs[i].v);
      chk($sformatf("busy_v%0d", i), busy, 1);
      wait_idle($sformatf("v%0d", i));
    end

    c0  = cyc;
    nd0 = n_done;
    push(c0 + 24, 1'b0, none);
    send(32'h40000000);
    repeat (2) @(negedge clk);
    send(32'h20000000);
    @(negedge clk);
    push(c0 + 47, 1'b1, mk(1'b0, 0, 250000));
    send(32'h10000000);
    wait_idle("b2b");
    chk("b2b_done_count", n_done - nd0, 2);

    send(32'h40000000);
    repeat (8) @(negedge clk);
    send(32'h20000000);
    @(negedge clk);
    chk("midreset_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", busy, 0);
    nd0 = n_done;
    repeat (60) @(negedge clk);
    chk("midreset_no_done", n_done - nd0, 0);
    scan_q.push_back(mk(1'b0, 0, 0));
    wait_idle("midreset_disp");

    chk("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
